// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, MSI encodings and refill FSM states for the dcache refill controller
package dcache_pkg;

    localparam int AddressSize = 32;
    localparam int WordSize    = 32;
    localparam int LineBeats   = 8;
    localparam int LineW       = WordSize * LineBeats;

    localparam int TagW     = 17;
    localparam int IndexW   = 10;
    localparam int OffsetW  = 5;
    localparam int TagLsb   = 15;
    localparam int IndexLsb = 5;
    localparam int BeatW    = 3;

    localparam logic [BeatW-1:0] LastBeat = BeatW'(LineBeats - 1);

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b11
    } msi_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL,
        ST_INSTALL
    } refill_state_e;

    function automatic int word_lsb(input logic [BeatW-1:0] beat);
        return int'(beat) * WordSize;
    endfunction

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// rtl/dcache_refill_ctrl_if.sv - word-wide memory beat port between the refill controller and main memory
interface dcache_refill_ctrl_if;
    import dcache_pkg::*;

    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [AddressSize-1:0] mem_addr_o;
    logic [WordSize-1:0]    mem_wdata_o;
    logic [WordSize-1:0]    mem_rdata_i;
    logic                   mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );

endinterface

// File: rtl/dcache_line_buffer.sv
// rtl/dcache_line_buffer.sv - 256-bit line register with whole-line load, per-beat word insert and extract
module dcache_line_buffer
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [LineW-1:0]    line_i,
    input  logic                wr_en_i,
    input  logic [BeatW-1:0]    wr_idx_i,
    input  logic [WordSize-1:0] wr_data_i,
    input  logic [BeatW-1:0]    rd_idx_i,
    output logic [WordSize-1:0] rd_data_o,
    output logic [LineW-1:0]    line_o
);

    logic [LineW-1:0] line_q;
    logic [LineW-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = line_i;
        end else if (wr_en_i) begin
            line_d[word_lsb(wr_idx_i) +: WordSize] = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign rd_data_o = line_q[word_lsb(rd_idx_i) +: WordSize];
    assign line_o    = line_q;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// rtl/dcache_refill_ctrl.sv - dcache miss responder: dirty victim write-back, 8-beat line fill, one-cycle install
module dcache_refill_ctrl
    import dcache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_rd_i,
    input  logic                   miss_wr_i,
    input  logic [AddressSize-1:0] miss_addr_i,
    input  logic [TagW-1:0]        victim_tag_i,
    input  logic [1:0]             victim_state_i,
    input  logic [LineW-1:0]       victim_line_i,
    output logic                   busy_o,
    output logic                   refill_we_o,
    output logic [IndexW-1:0]      refill_index_o,
    output logic [TagW-1:0]        refill_tag_o,
    output logic [1:0]             refill_state_o,
    output logic [LineW-1:0]       refill_line_o,
    dcache_refill_ctrl_if.master   mem
);

    refill_state_e     state_q, state_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [TagW-1:0]   tag_q, tag_d;
    logic [IndexW-1:0] index_q, index_d;
    logic [TagW-1:0]   vtag_q, vtag_d;
    logic              wr_q, wr_d;

    logic              lb_load;
    logic              lb_wr;
    logic [WordSize-1:0] lb_rd_data;
    logic [LineW-1:0]  lb_line;

    logic [TagW-1:0]   req_tag;
    logic [IndexW-1:0] req_index;
    logic              offset_unused;

    assign req_tag       = miss_addr_i[AddressSize-1:TagLsb];
    assign req_index     = miss_addr_i[TagLsb-1:IndexLsb];
    assign offset_unused = ^miss_addr_i[OffsetW-1:0];

    // The buffer holds the victim line on acceptance; write-back drains word k
    // before the fill overwrites it, so one buffer serves both phases.
    dcache_line_buffer u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (lb_load),
        .line_i    (victim_line_i),
        .wr_en_i   (lb_wr),
        .wr_idx_i  (beat_q),
        .wr_data_i (mem.mem_rdata_i),
        .rd_idx_i  (beat_q),
        .rd_data_o (lb_rd_data),
        .line_o    (lb_line)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tag_d   = tag_q;
        index_d = index_q;
        vtag_d  = vtag_q;
        wr_d    = wr_q;
        lb_load = 1'b0;
        lb_wr   = 1'b0;

        busy_o         = 1'b0;
        refill_we_o    = 1'b0;
        refill_index_o = '0;
        refill_tag_o   = '0;
        refill_state_o = '0;
        refill_line_o  = '0;
        mem.mem_req_o   = 1'b0;
        mem.mem_we_o    = 1'b0;
        mem.mem_addr_o  = '0;
        mem.mem_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (miss_rd_i || miss_wr_i) begin
                    tag_d   = req_tag;
                    index_d = req_index;
                    vtag_d  = victim_tag_i;
                    wr_d    = miss_wr_i;
                    beat_d  = '0;
                    lb_load = 1'b1;
                    if (miss_wr_i && (victim_state_i == MSI_S) && (victim_tag_i == req_tag)) begin
                        state_d = ST_INSTALL;
                    end else if ((victim_state_i == MSI_M) && (victim_tag_i != req_tag)) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_WB: begin
                busy_o          = 1'b1;
                mem.mem_req_o   = 1'b1;
                mem.mem_we_o    = 1'b1;
                mem.mem_addr_o  = {vtag_q, index_q, beat_q, 2'b00};
                mem.mem_wdata_o = lb_rd_data;
                if (mem.mem_ack_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                busy_o         = 1'b1;
                mem.mem_req_o  = 1'b1;
                mem.mem_addr_o = {tag_q, index_q, beat_q, 2'b00};
                if (mem.mem_ack_i) begin
                    lb_wr  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = ST_INSTALL;
                    end
                end
            end

            ST_INSTALL: begin
                busy_o         = 1'b1;
                refill_we_o    = 1'b1;
                refill_index_o = index_q;
                refill_tag_o   = tag_q;
                refill_state_o = wr_q ? MSI_M : MSI_S;
                refill_line_o  = lb_line;
                state_d        = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            index_q <= '0;
            vtag_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            vtag_q  <= vtag_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb/tb_dcache_refill_ctrl.sv - self-checking bench for dcache_refill_ctrl: vector table, reset abort, random misses
module tb_dcache_refill_ctrl;
    import dcache_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [16:0] vt;
        logic [1:0]  vs;
        int          maxwait;
        bit          hold;
        bit          pulse2;
        int          exp_cyc;
        int          exp_nb;
        logic [1:0]  exp_state;
        logic [31:0] exp_a0;
        logic [9:0]  exp_idx;
        logic [16:0] exp_tag;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_rd, miss_wr;
    logic [31:0]  miss_addr;
    logic [16:0]  vtag;
    logic [1:0]   vstate;
    logic [255:0] vline;
    logic         busy, refill_we;
    logic [9:0]   refill_index;
    logic [16:0]  refill_tag;
    logic [1:0]   refill_state;
    logic [255:0] refill_line;

    dcache_refill_ctrl_if mem_bus ();

    dcache_refill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .miss_rd_i      (miss_rd),
        .miss_wr_i      (miss_wr),
        .miss_addr_i    (miss_addr),
        .victim_tag_i   (vtag),
        .victim_state_i (vstate),
        .victim_line_i  (vline),
        .busy_o         (busy),
        .refill_we_o    (refill_we),
        .refill_index_o (refill_index),
        .refill_tag_o   (refill_tag),
        .refill_state_o (refill_state),
        .refill_line_o  (refill_line),
        .mem            (mem_bus)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cur_id;
    logic [31:0]  mem_seed;
    beat_t        obs_beats[$];
    beat_t        exp_beats[$];
    int           obs_inst_cyc, obs_we_cnt, obs_waits;
    bit           obs_timeout, obs_busy1, obs_busy_after;
    logic [9:0]   obs_idx;
    logic [16:0]  obs_tag;
    logic [1:0]   obs_state;
    logic [255:0] obs_line, exp_line;
    logic [1:0]   exp_state;
    vec_t         tbl[9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [%0d] %s: got %0h want %0h", cur_id, name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_outputs_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_refill_we"}, refill_we, 0);
        chk({name, "_refill_index"}, refill_index, 0);
        chk({name, "_refill_tag"}, refill_tag, 0);
        chk({name, "_refill_state"}, refill_state, 0);
        chk({name, "_refill_line"}, refill_line, 0);
        chk({name, "_mem_req"}, mem_bus.mem_req_o, 0);
        chk({name, "_mem_we"}, mem_bus.mem_we_o, 0);
        chk({name, "_mem_addr"}, mem_bus.mem_addr_o, 0);
        chk({name, "_mem_wdata"}, mem_bus.mem_wdata_o, 0);
    endtask

    // Entered at a negedge with the DUT idle; acts as cache and memory until the
    // cycle after the install strobe. Cycle k is observed at the k-th negedge.
    task automatic do_miss(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [16:0] t, input logic [1:0] s, input logic [255:0] line,
                           input int maxwait, input bit hold, input bit pulse2);
        int    cyc;
        int    wl;
        bit    pending, done;
        beat_t held, b;
        obs_beats.delete();
        obs_we_cnt = 0; obs_inst_cyc = -1; obs_waits = 0; obs_timeout = 0;
        obs_busy1 = 0; obs_busy_after = 1;
        miss_rd = rd; miss_wr = wr; miss_addr = addr; vtag = t; vstate = s; vline = line;
        cyc = 0; wl = 0; pending = 0; done = 0; held = '0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                obs_busy1 = busy;
                if (!hold) begin
                    miss_rd = 1'b0; miss_wr = 1'b0;
                    vline = rand_line(); vtag = 17'($urandom); vstate = 2'($urandom);
                end
            end
            if (pulse2 && cyc == 3) begin
                miss_rd = 1'b1; miss_addr = $urandom;
            end else if (pulse2 && cyc == 4) begin
                miss_rd = 1'b0;
            end
            if (mem_bus.mem_req_o) begin
                if (pending) begin
                    chk("beat_stable_while_waiting",
                        {mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o}, held);
                end else begin
                    wl = $urandom_range(maxwait, 0);
                    held = {mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o};
                end
                if (wl == 0) begin
                    mem_bus.mem_ack_i = 1'b1;
                    mem_bus.mem_rdata_i = mem_word(mem_bus.mem_addr_o);
                    pending = 0;
                    b.we   = mem_bus.mem_we_o;
                    b.addr = mem_bus.mem_addr_o;
                    b.data = mem_bus.mem_we_o ? mem_bus.mem_wdata_o : mem_word(mem_bus.mem_addr_o);
                    obs_beats.push_back(b);
                end else begin
                    mem_bus.mem_ack_i = 1'b0;
                    mem_bus.mem_rdata_i = $urandom;
                    wl--;
                    pending = 1;
                    obs_waits++;
                end
            end else begin
                if (pending) chk("req_dropped_before_ack", mem_bus.mem_req_o, 1);
                pending = 0;
                mem_bus.mem_ack_i = 1'($urandom);
                mem_bus.mem_rdata_i = $urandom;
            end
            if (refill_we) begin
                obs_we_cnt++;
                if (obs_inst_cyc < 0) begin
                    obs_inst_cyc = cyc;
                    obs_idx = refill_index; obs_tag = refill_tag;
                    obs_state = refill_state; obs_line = refill_line;
                end
                if (hold) begin
                    miss_rd = 1'b0; miss_wr = 1'b0;
                end
            end
            if (obs_inst_cyc >= 0 && cyc > obs_inst_cyc) begin
                obs_busy_after = busy;
                done = 1;
            end
            if (cyc > 400) begin
                obs_timeout = 1;
                done = 1;
            end
        end
    endtask

    // Expected traffic and install derived directly from the miss rules.
    task automatic check_model(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [16:0] t, input logic [1:0] s, input logic [255:0] line);
        logic [16:0] rt;
        logic [9:0]  ri;
        logic [2:0]  kb;
        logic [31:0] a;
        bit          upg, wb;
        beat_t       b;
        rt = addr[31:15];
        ri = addr[14:5];
        upg = wr && (s == 2'b01) && (t == rt);
        wb  = !upg && (s == 2'b11) && (t != rt);
        exp_beats.delete();
        exp_line = line;
        if (wb) begin
            for (int k = 0; k < 8; k++) begin
                kb = k[2:0];
                a = {t, ri, kb, 2'b00};
                b = {1'b1, a, line[32*k +: 32]};
                exp_beats.push_back(b);
            end
        end
        if (!upg) begin
            for (int k = 0; k < 8; k++) begin
                kb = k[2:0];
                a = {rt, ri, kb, 2'b00};
                b = {1'b0, a, mem_word(a)};
                exp_beats.push_back(b);
                exp_line[32*k +: 32] = mem_word(a);
            end
        end
        exp_state = (rd && !wr) ? 2'b01 : 2'b11;
        chk("timeout", obs_timeout, 0);
        chk("refill_we_pulses", obs_we_cnt, 1);
        chk("busy_cycle_after_accept", obs_busy1, 1);
        chk("busy_after_install", obs_busy_after, 0);
        chk("beat_count", obs_beats.size(), exp_beats.size());
        for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++)
            chk("beat_we_addr_data", obs_beats[i], exp_beats[i]);
        chk("install_cycle", obs_inst_cyc, 1 + exp_beats.size() + obs_waits);
        chk("install_index", obs_idx, ri);
        chk("install_tag", obs_tag, rt);
        chk("install_state", obs_state, exp_state);
        chk("install_line", obs_line, exp_line);
    endtask

    initial begin
        logic [255:0] line;
        logic [31:0]  r_addr;
        logic [16:0]  r_vt;
        logic [1:0]   r_vs;
        logic         r_rd, r_wr;
        int           sel, nack, guard;
        bit           hit;

        tbl[0] = '{rd:1, wr:0, addr:32'h0001_2340, vt:17'h0,     vs:2'b00, maxwait:0, hold:1, pulse2:0,
                   exp_cyc:9,  exp_nb:8,  exp_state:2'b01, exp_a0:32'h0001_2340, exp_idx:10'h11A, exp_tag:17'h2};
        tbl[1] = '{rd:0, wr:1, addr:32'h0001_2340, vt:17'h1,     vs:2'b11, maxwait:0, hold:0, pulse2:0,
                   exp_cyc:17, exp_nb:16, exp_state:2'b11, exp_a0:32'h0000_A340, exp_idx:10'h11A, exp_tag:17'h2};
        tbl[2] = '{rd:0, wr:1, addr:32'h0001_2340, vt:17'h2,     vs:2'b01, maxwait:0, hold:1, pulse2:0,
                   exp_cyc:1,  exp_nb:0,  exp_state:2'b11, exp_a0:32'h0,         exp_idx:10'h11A, exp_tag:17'h2};
        tbl[3] = '{rd:1, wr:1, addr:32'h0004_0080, vt:17'h0,     vs:2'b00, maxwait:0, hold:0, pulse2:1,
                   exp_cyc:9,  exp_nb:8,  exp_state:2'b11, exp_a0:32'h0004_0080, exp_idx:10'h004, exp_tag:17'h8};
        tbl[4] = '{rd:1, wr:0, addr:32'h0007_FFFF, vt:17'hF,     vs:2'b11, maxwait:0, hold:0, pulse2:0,
                   exp_cyc:9,  exp_nb:8,  exp_state:2'b01, exp_a0:32'h0007_FFE0, exp_idx:10'h3FF, exp_tag:17'hF};
        tbl[5] = '{rd:0, wr:1, addr:32'h8000_0020, vt:17'h1,     vs:2'b01, maxwait:0, hold:1, pulse2:0,
                   exp_cyc:9,  exp_nb:8,  exp_state:2'b11, exp_a0:32'h8000_0020, exp_idx:10'h001, exp_tag:17'h10000};
        tbl[6] = '{rd:1, wr:0, addr:32'h0001_2340, vt:17'h2,     vs:2'b01, maxwait:0, hold:0, pulse2:0,
                   exp_cyc:9,  exp_nb:8,  exp_state:2'b01, exp_a0:32'h0001_2340, exp_idx:10'h11A, exp_tag:17'h2};
        tbl[7] = '{rd:0, wr:1, addr:32'hFFFF_FFE4, vt:17'h1FFFF, vs:2'b11, maxwait:0, hold:1, pulse2:0,
                   exp_cyc:9,  exp_nb:8,  exp_state:2'b11, exp_a0:32'hFFFF_FFE0, exp_idx:10'h3FF, exp_tag:17'h1FFFF};
        tbl[8] = '{rd:1, wr:0, addr:32'h0000_0000, vt:17'h1FFFF, vs:2'b11, maxwait:0, hold:0, pulse2:1,
                   exp_cyc:17, exp_nb:16, exp_state:2'b01, exp_a0:32'hFFFF_8000, exp_idx:10'h000, exp_tag:17'h0};

        cur_id = -1;
        rst = 1'b1;
        miss_rd = 1'b0; miss_wr = 1'b0; miss_addr = '0;
        vtag = '0; vstate = '0; vline = '0;
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hDEAD_BEEF;
        mem_seed = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        mem_bus.mem_ack_i = 1'b0;

        for (int v = 0; v < 9; v++) begin
            cur_id = v;
            mem_seed = $urandom;
            line = rand_line();
            do_miss(tbl[v].rd, tbl[v].wr, tbl[v].addr, tbl[v].vt, tbl[v].vs, line,
                    tbl[v].maxwait, tbl[v].hold, tbl[v].pulse2);
            check_model(tbl[v].rd, tbl[v].wr, tbl[v].addr, tbl[v].vt, tbl[v].vs, line);
            chk("tbl_install_cycle", obs_inst_cyc, tbl[v].exp_cyc);
            chk("tbl_beat_count", obs_beats.size(), tbl[v].exp_nb);
            chk("tbl_state", obs_state, tbl[v].exp_state);
            chk("tbl_index", obs_idx, tbl[v].exp_idx);
            chk("tbl_tag", obs_tag, tbl[v].exp_tag);
            if (tbl[v].exp_nb > 0 && obs_beats.size() > 0)
                chk("tbl_first_beat_addr", obs_beats[0].addr, tbl[v].exp_a0);
        end

        // Reset while FILL beat 4 is outstanding, then a stale ack.
        cur_id = 100;
        miss_rd = 1'b1; miss_wr = 1'b0; miss_addr = 32'h0001_2340;
        vtag = '0; vstate = 2'b00;
        nack = 0; guard = 0; hit = 0;
        while (!hit && guard < 40) begin
            @(negedge clk);
            miss_rd = 1'b0;
            guard++;
            if (mem_bus.mem_req_o && nack == 4) begin
                hit = 1;
                mem_bus.mem_ack_i = 1'b0;
            end else if (mem_bus.mem_req_o) begin
                mem_bus.mem_ack_i = 1'b1;
                nack++;
            end else begin
                mem_bus.mem_ack_i = 1'b0;
            end
        end
        chk("reached_fill_beat4", hit, 1);
        chk("fill_beat4_addr", mem_bus.mem_addr_o, 32'h0001_2350);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_bus.mem_ack_i = 1'b1;
        mem_bus.mem_rdata_i = $urandom;
        check_outputs_zero("after_abort");
        @(negedge clk);
        mem_bus.mem_ack_i = 1'b0;
        chk("stale_ack_busy", busy, 0);
        chk("stale_ack_mem_req", mem_bus.mem_req_o, 0);
        chk("stale_ack_refill_we", refill_we, 0);
        cur_id = 101;
        mem_seed = $urandom;
        line = rand_line();
        do_miss(1'b1, 1'b0, 32'h0001_2340, 17'h0, 2'b00, line, 0, 0, 0);
        check_model(1'b1, 1'b0, 32'h0001_2340, 17'h0, 2'b00, line);
        if (obs_beats.size() > 0)
            chk("post_abort_first_addr", obs_beats[0].addr, 32'h0001_2340);

        for (int i = 0; i < 40; i++) begin
            cur_id = 200 + i;
            mem_seed = $urandom;
            r_addr = $urandom;
            r_vt = ($urandom_range(1, 0) == 1) ? r_addr[31:15] : 17'($urandom);
            sel = $urandom_range(2, 0);
            r_vs = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            sel = $urandom_range(2, 0);
            r_rd = (sel != 1);
            r_wr = (sel != 0);
            line = rand_line();
            do_miss(r_rd, r_wr, r_addr, r_vt, r_vs, line, 3, (i % 2) == 1, 0);
            check_model(r_rd, r_wr, r_addr, r_vt, r_vs, line);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Miss-side responder for the data cache. It accepts the cache's read-miss and write-miss indications and writes back a Modified victim line word by word.
- It then fills the requested 256-bit line from word-wide main memory and returns the line with its new tag and MSI state for the cache to install.
- It sits between the data cache and the memory/bus port. All line traffic is 8 beats of 32 bits.

Parameters:
- AddressSize, 32, byte address width; fixed split tag[31:15], index[14:5], offset[4:0].
- WordSize, 32, memory beat width.
- LineBeats, 8, words per cache line (256/WordSize).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_rd_i  in  1  cache read miss
- miss_wr_i  in  1  cache write miss
- miss_addr_i  in  32  missing byte address
- victim_tag_i  in  17  tag currently stored at miss index
- victim_state_i  in  2  MSI state at miss index (00 I, 01 S, 11 M)
- victim_line_i  in  256  line data currently at miss index
- busy_o  out  1  controller owns a miss; cache must stall
- refill_we_o  out  1  one-cycle install strobe
- refill_index_o  out  10  line index to install
- refill_tag_o  out  17  tag to install
- refill_state_o  out  2  state to install (Shared for read, Modified for write)
- refill_line_o  out  256  line data to install
- mem_req_o  out  1  memory beat request
- mem_we_o  out  1  1 = write beat, 0 = read beat
- mem_addr_o  out  32  word-aligned beat address
- mem_wdata_o  out  32  write beat data
- mem_rdata_i  in  32  read beat data, valid with mem_ack_i
- mem_ack_i  in  1  beat accepted/completed

Behaviour:
- Reset: all outputs 0, FSM to IDLE, beat counter 0, capture registers 0. Reset mid-transfer aborts immediately. No refill_we_o is issued. A mem_ack_i arriving after reset is ignored.
- FSM states: IDLE, WB, FILL, INSTALL.
- IDLE: when miss_rd_i|miss_wr_i, latch addr, kind, victim tag/state/line.
  - If both rd and wr are asserted, treat as a write.
  - Upgrade: write miss with victim_state=S and victim_tag=req tag. Go straight to INSTALL with line=victim_line, state=M. No memory traffic.
  - Else if victim_state=M and victim_tag≠req tag: go to WB.
  - Else: go to FILL.
- busy_o = 1 in every state except IDLE. It is asserted the cycle after acceptance.
- Memory handshake:
  - mem_req_o stays high with addr/we/wdata stable until a cycle where mem_ack_i=1. That cycle completes one beat.
  - The next beat's request may follow immediately (back-to-back).
  - mem_ack_i is ignored while mem_req_o=0.
- WB: mem_we_o=1.
  - Beat k address = {victim_tag, index, k[2:0], 2'b00}.
  - wdata = victim_line[32k +: 32], k = 0..7.
  - After the ack of beat 7: counter to 0, go to FILL.
- FILL: mem_we_o=0.
  - Beat k address = {req_tag, index, k[2:0], 2'b00}.
  - On ack, mem_rdata_i is stored at line buffer bits [32k +: 32].
  - After the ack of beat 7: go to INSTALL.
- INSTALL: exactly one cycle.
  - refill_we_o=1; index/tag/state/line valid for that cycle only.
  - Next state IDLE.
  - A miss asserted in the cycle after INSTALL is a new miss and is accepted normally.
- Misses arriving while busy are ignored; the cache holds them asserted until serviced.
- Beat counter is 3 bits; wrap 7→0 is the end-of-phase condition.
- Latency, read miss with clean victim and ack every cycle:
  - accept at cycle 0
  - mem_req_o cycles 1–8
  - refill_we_o at cycle 9
  - IDLE at cycle 10
- Latency, dirty victim: +8 beats.
- Latency, upgrade: refill_we_o at cycle 1.

Decomposition:
- Package dcache_pkg holds:
  - MSI encodings (Invalid 2'b00, Shared 2'b01, Modified 2'b11)
  - tag/index/offset widths and bit positions
  - LineBeats
  - refill FSM state enum
- Natural sub-module: dcache_line_buffer, a 256-bit register with word insert (write k, data) and word extract (read k) by beat index.

Test Plan:
- Read miss, addr 0x0001_2340, victim I, ack every cycle:
  - 8 read beats at 0x0001_2340..0x0001_235C.
  - refill_we_o at cycle 9, index 0x11A, tag 0x0002, state 01.
  - refill_line word k = rdata k.
- Write miss, victim M with tag 0x1, same index 0x11A, req tag 0x2:
  - 8 write beats at 0x0000_A340..0x0000_A35C carrying victim words.
  - Then 8 reads at 0x0001_2340..0x0001_235C.
  - Install with state 11.
- Write miss, victim S, tag match:
  - No mem_req_o.
  - refill_we_o at cycle 1, state 11, line = victim_line.
- Ack with random 0–3 wait cycles per beat:
  - addr/wdata stable while waiting.
  - Beat count exactly 8 per phase.
  - Install data correct.
- rst asserted during FILL beat 4, with a stale ack one cycle later:
  - All outputs 0 after reset.
  - No refill_we_o.
  - A new read miss afterwards starts at beat 0.
- miss_rd_i and miss_wr_i both asserted together, clean victim:
  - Handled as write: fill then install with state 11.
  - A second miss pulse while busy is ignored.
